fifo_sync_fwft: RTL
===================

// Module: fifo_sync_fwft
// PURPOSE
// - Parametrised single-clock FIFO with selectable read mode (first-word-fall-through or registered).
// - Provides occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow errors and synchronous flush.
// - General buffering element for the core: fetch queue, load/store buffer, UART/peripheral staging.
// PARAMETERS
// - DATA_WIDTH  32  word width in bits (>=1)
// - DEPTH       32  entries; power of two, >=2
// - FWFT        1   1: head word visible on o_data while o_valid; 0: registered read, data 1 cycle after pop
// - AFULL_LVL   DEPTH-4  o_almost_full when count >= AFULL_LVL
// - AEMPTY_LVL  4   o_almost_empty when count <= AEMPTY_LVL
// - localparam AW = $clog2(DEPTH)
// PORTS
// - i_clk           in   1      clock, rising edge
// - i_rst           in   1      asynchronous reset, active-high
// - i_flush         in   1      synchronous flush; empties FIFO, clears error flags
// - i_write_en      in   1      write request
// - i_data          in   DW     write data
// - i_read_en       in   1      read/pop request
// - o_data          out  DW     read data
// - o_valid         out  1      o_data holds a valid word (see BEHAVIOUR)
// - o_full/o_empty  out  1      count==DEPTH / count==0
// - o_almost_full   out  1      count >= AFULL_LVL
// - o_almost_empty  out  1      count <= AEMPTY_LVL
// - o_count         out  AW+1   current occupancy 0..DEPTH
// - o_overflow      out  1      sticky: write attempted while full
// - o_underflow     out  1      sticky: read attempted while empty
// BEHAVIOUR
// - Reset (async assert, release synchronous to i_clk): ptrs=0, count=0, o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0 (AFULL_LVL>0), o_data=0, o_valid=0, errors=0. Memory contents not cleared.
// - Pointers AW+1 bits (wrap bit); empty when equal, full when low bits equal and wrap bits differ; natural wrap past DEPTH-1.
// - Write accepted = i_write_en & !o_full, evaluated on pre-edge state; a write while full is dropped even if a read is accepted the same cycle.
// - Read accepted = i_read_en & !o_empty (pre-edge state).
// - Both accepted: count unchanged, both pointers advance; legal at any count 1..DEPTH-1.
// - All flags/count registered; updated on the edge of the accepted op (write at edge N -> o_empty=0 from cycle N+1).
// - FWFT=1: o_valid = !o_empty; o_data = mem[rd_ptr] (combinational read); pop on accepted read exposes next word the following cycle. Write into empty FIFO visible on o_data the cycle after the write edge.
// - FWFT=0: o_data registered; accepted read at edge N -> o_data valid and o_valid=1 in cycle N+1 only; o_data holds last value otherwise; o_valid=0 when no accepted read.
// - o_overflow set on i_write_en & o_full; o_underflow set on i_read_en & o_empty; both hold until i_rst or i_flush.
// - i_flush: at edge, ptrs/count/errors -> reset values, o_valid=0; overrides any concurrent read/write (both discarded, no error set).
// - Reset mid-operation: in-flight words discarded, outputs take reset values immediately, no clock needed.
// - FORMAL: assume no req in first cycle; assert count==wr_ptr-rd_ptr, !(o_full&o_empty), count<=DEPTH.
// STRUCTURE
// - fifo_pkg: ptr/count width helper functions, error-flag struct {overflow, underflow}.
// - Sub-module fifo_mem: simple dual-port RAM (1W, 1R), parameter SYNC_READ selects async (FWFT=1) or registered (FWFT=0) read.
// - Top holds pointers, count, flags, error logic; no other sub-modules.
// TESTING (DEPTH=8, DW=32, AFULL_LVL=6, AEMPTY_LVL=2 unless noted)
// - Write 0x11,0x22,0x33,0x44 -> count=4, almost_empty=0; 4 reads return 0x11..0x44 in order, o_empty=1 after last edge.
// - 9 consecutive writes -> o_full=1 after 8th, almost_full=1 after 6th, 9th dropped, o_overflow=1, readback 8 words intact.
// - Full FIFO, read+write same cycle -> read accepted, write dropped, count=7, o_overflow=1.
// - At count=3, 20 cycles of read+write -> count stays 3, pointers wrap, data order preserved.
// - Read when empty -> o_underflow=1, o_valid=0; then i_flush -> o_underflow=0, count=0.
// - FWFT=0 build: read at edge N -> o_data valid with o_valid=1 at N+1 only; i_rst asserted mid-burst -> all outputs reset without clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the synchronous FIFO.
// Pointers and the occupancy count both carry one extra bit.
package fifo_pkg;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one write port, one read port.
// SYNC_READ=0 gives a combinational read, SYNC_READ=1 a registered one.
module fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter bit SYNC_READ  = 1'b0,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage is deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    if (SYNC_READ) begin : g_sync
        logic [DATA_WIDTH-1:0] rdata_q;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                rdata_q <= '0;
            end else if (i_re) begin
                rdata_q <= mem_q[i_raddr];
            end
        end

        assign o_rdata = rdata_q;
    end else begin : g_async
        logic unused_rd;

        assign unused_rd = i_re ^ i_rst;
        assign o_rdata   = mem_q[i_raddr];
    end

endmodule

// File: rtl/fifo_sync_fwft.sv
// Single-clock FIFO with first-word-fall-through or registered read,
// registered occupancy flags, sticky error flags and synchronous flush.
module fifo_sync_fwft
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter bit FWFT       = 1'b1,
    parameter int AFULL_LVL  = DEPTH - 4,
    parameter int AEMPTY_LVL = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_write_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_read_en,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [AW:0]           o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    localparam logic [CW-1:0] AF_LVL  = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AE_LVL  = CW'(AEMPTY_LVL);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic          AF_RST  = (AFULL_LVL <= 0);
    localparam logic          AE_RST  = (AEMPTY_LVL >= 0);

    typedef logic [PW-1:0] ptr_t;

    ptr_t            wr_ptr_q, wr_ptr_d;
    ptr_t            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            afull_q, afull_d;
    logic            aempty_q, aempty_d;
    logic            valid_q, valid_d;
    fifo_err_t       err_q, err_d;

    logic            wr_do;
    logic            rd_do;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Acceptance uses pre-edge flags; flush discards both requests.
    assign wr_do = i_write_en & ~full_q & ~i_flush;
    assign rd_do = i_read_en & ~empty_q & ~i_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        valid_d  = 1'b0;

        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            err_d    = '0;
        end else begin
            if (wr_do) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_do) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({wr_do, rd_do})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            err_d.overflow  = err_q.overflow | (i_write_en & full_q);
            err_d.underflow = err_q.underflow | (i_read_en & empty_q);
            valid_d         = rd_do;
        end

        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                   (wr_ptr_d[AW] != rd_ptr_d[AW]);
        afull_d  = (count_d >= AF_LVL);
        aempty_d = (count_d <= AE_LVL);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= AF_RST;
            aempty_q <= AE_RST;
            valid_q  <= 1'b0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .SYNC_READ  (!FWFT)
    ) u_mem (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (wr_do),
        .i_waddr (wr_ptr_q[AW-1:0]),
        .i_wdata (i_data),
        .i_re    (rd_do),
        .i_raddr (rd_ptr_q[AW-1:0]),
        .o_rdata (mem_rdata)
    );

    // In FWFT mode the head is masked to zero while empty.
    assign o_valid        = FWFT ? ~empty_q : valid_q;
    assign o_data         = (FWFT && empty_q) ? '0 : mem_rdata;
    assign o_full         = full_q;
    assign o_empty        = empty_q;
    assign o_almost_full  = afull_q;
    assign o_almost_empty = aempty_q;
    assign o_count        = count_q;
    assign o_overflow     = err_q.overflow;
    assign o_underflow    = err_q.underflow;

    a_count_ptr : assert property (@(posedge i_clk) disable iff (i_rst)
        count_q == CW'(wr_ptr_q - rd_ptr_q));
    a_not_full_empty : assert property (@(posedge i_clk) disable iff (i_rst)
        !(full_q && empty_q));
    a_count_max : assert property (@(posedge i_clk) disable iff (i_rst)
        count_q <= DEPTH_C);

endmodule
